if_id_skid_buffer: RTL and testbench

// - IF/ID pipeline boundary, directly downstream of instruction fetch. Captures {pc, instruction} from

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_entry_reg.sv | 17 +
 rtl/if_id_skid_buffer.sv | 104 ++++++++++
 tb/tb_if_id_skid_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the IF/ID boundary: skid buffer state, default bubble, entry layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam int PIPE_DW = 16;
  localparam logic [PIPE_DW-1:0] NOP_INSTR_DEF = 16'h0000;

  typedef struct packed {
    logic [PIPE_DW-1:0] pc;
    logic [PIPE_DW-1:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enable register holding one {pc, instr} entry; clears on synchronous reset.
module pipe_entry_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/if_id_skid_buffer.sv
// IF/ID 2-entry skid buffer: fetch_ready comes straight from a flop, so decode_ready
// never reaches fetch combinationally. Flush empties the buffer; stall cycles are counted.
module if_id_skid_buffer
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NOP_INSTR_DEF,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  input  logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] decode_pc,
  output logic [DATA_WIDTH-1:0] decode_instr,
  output logic                  decode_valid,
  input  logic                  decode_ready,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam int EW = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  buf_state_e    state, state_nxt;
  logic [EW-1:0] fetch_ent, main_d, main_q, skid_q;
  logic          in_fire, out_fire, main_ld, skid_ld;

  assign fetch_ent = {fetch_pc, fetch_instr};
  assign in_fire   = fetch_valid & fetch_ready;
  assign out_fire  = decode_valid & decode_ready;

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = fetch_ent;
    case (state)
      EMPTY: if (in_fire) begin
        state_nxt = ONE;
        main_ld   = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) main_ld = 1'b1;
        else if (in_fire) begin
          state_nxt = FULL;
          skid_ld   = 1'b1;
        end else if (out_fire) state_nxt = EMPTY;
      end
      FULL: if (out_fire) begin
        state_nxt = ONE;
        main_ld   = 1'b1;
        main_d    = skid_q;
      end
      default: state_nxt = EMPTY;
    endcase
    // Handshakes still complete on both sides, but nothing accepted survives a flush.
    if (flush) begin
      state_nxt = EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      fetch_ready  <= 1'b1;
      decode_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_ready  <= (state_nxt != FULL);
      decode_valid <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (decode_valid && !decode_ready && stall_count != CNT_MAX)
      stall_count <= stall_count + 1'b1;
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .ld    (skid_ld),
    .d     (fetch_ent),
    .q     (skid_q)
  );

  assign decode_pc    = main_q[EW-1 -: DATA_WIDTH];
  assign decode_instr = decode_valid ? main_q[DATA_WIDTH-1:0] : NOP_INSTR;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Scoreboard bench: accepted fetches are queued as expected decode entries; the monitor
// compares the head and pops on each consume. A 4-bit-counter copy checks saturation.
module tb_if_id_skid_buffer;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc, fetch_instr;
  logic        fetch_valid, flush, decode_ready;
  logic        fetch_ready, decode_valid;
  logic [15:0] decode_pc, decode_instr, stall_count;
  logic        f4_ready, d4_valid;
  logic [15:0] d4_pc, d4_instr;
  logic [3:0]  sc4;

  int checks   = 0;
  int failures = 0;
  int stall_exp = 0;
  if_id_entry_t exp_q[$];

  always #5 clk = ~clk;

  if_id_skid_buffer dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .flush(flush),
    .decode_pc(decode_pc), .decode_instr(decode_instr), .decode_valid(decode_valid),
    .decode_ready(decode_ready), .stall_count(stall_count)
  );

  if_id_skid_buffer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .fetch_ready(f4_ready), .flush(flush),
    .decode_pc(d4_pc), .decode_instr(d4_instr), .decode_valid(d4_valid),
    .decode_ready(decode_ready), .stall_count(sc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: record what fetch handed over (after the monitor has popped this cycle).
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (flush) exp_q.delete();
      else if (fetch_valid && fetch_ready) exp_q.push_back('{pc: fetch_pc, instr: fetch_instr});
    end
  end

  // Monitor: outputs vs. reference queue; head is compared every cycle and popped on consume.
  always @(negedge clk) begin
    if (!reset) begin
      chk("fetch_ready", fetch_ready, exp_q.size() < 2);
      chk("decode_valid", decode_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("decode_pc", decode_pc, exp_q[0].pc);
        chk("decode_instr", decode_instr, exp_q[0].instr);
      end else begin
        chk("bubble_nop", decode_instr, NOP_INSTR_DEF);
      end
      chk("stall_count16", stall_count, (stall_exp > 65535) ? 65535 : stall_exp);
      chk("stall_count4", sc4, (stall_exp > 15) ? 15 : stall_exp);
      if (exp_q.size() != 0 && !decode_ready) stall_exp++;
      if (exp_q.size() != 0 && decode_ready) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic fv, input logic [15:0] pc, input logic [15:0] ins,
                       input logic dr, input logic fl);
    logic r0;
    @(posedge clk); #1;
    fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; decode_ready = dr; flush = fl;
    // fetch_ready must not move when decode_ready toggles mid-cycle
    #1; r0 = fetch_ready;
    decode_ready = ~dr;
    #1; chk("ready_no_comb_path", fetch_ready, r0);
    decode_ready = dr;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
    flush = 1'b0; decode_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("reset_pc", decode_pc, 16'h0000);
    chk("reset_cnt", stall_count, 16'h0000);

    // streaming at full rate
    drive(1, 16'h0000, 16'h1111, 1, 0);
    drive(1, 16'h0002, 16'h2222, 1, 0);
    drive(1, 16'h0004, 16'h3333, 1, 0);
    repeat (2) drive(0, 16'h0, 16'h0, 1, 0);

    // fill with decode stalled, third offer held until accepted
    drive(1, 16'h0000, 16'h1111, 0, 0);
    drive(1, 16'h0002, 16'h2222, 0, 0);
    repeat (3) drive(1, 16'h0004, 16'h3333, 0, 0);
    repeat (2) drive(1, 16'h0004, 16'h3333, 1, 0);
    repeat (3) drive(0, 16'h0, 16'h0, 1, 0);

    // flush while full and stalled
    drive(1, 16'h0008, 16'haaaa, 0, 0);
    drive(1, 16'h000a, 16'hbbbb, 0, 0);
    drive(0, 16'h0, 16'h0, 0, 1);
    drive(1, 16'h0040, 16'h4444, 1, 0);
    repeat (2) drive(0, 16'h0, 16'h0, 1, 0);

    // flush coincident with acceptance while empty
    drive(1, 16'h0010, 16'h5555, 1, 1);
    repeat (2) drive(0, 16'h0, 16'h0, 1, 0);

    // long stall: 4-bit counter pins at 15
    drive(1, 16'h0020, 16'h6666, 0, 0);
    repeat (20) drive(0, 16'h0, 16'h0, 0, 0);
    @(negedge clk); #2;
    chk("sat4_at_15", sc4, 4'd15);
    repeat (2) drive(0, 16'h0, 16'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    repeat (4) drive(0, 16'h0, 16'h0, 1, 0);
    @(negedge clk); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
